divisor_sequencial: RTL

//  Iterative restoring divider. Computes one quotient bit per clock.

---
 rtl/divisor_sequencial.sv | 137 +++++++++++++
 1 files changed

// File: rtl/divisor_sequencial.sv
// Iterative restoring divider: one quotient bit per clock, start/busy/done
// handshake, runtime signed/unsigned mode, registered Q/R/E outputs.
module divisor_sequencial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sinal,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             E
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]       state;
    logic [CW-1:0]    count;

    // Datapath registers: latched dividend (for the divide-by-zero result),
    // dividend/quotient shift register, divisor magnitude, partial remainder.
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] prem;
    logic             neg_q;
    logic             neg_r;
    logic             zero;

    // One restoring step, WIDTH+1 bits wide so the sign of the trial
    // subtraction is visible. Either surviving value is < |B| and fits WIDTH bits.
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // Magnitude of an operand; in unsigned mode the value passes through.
    // The most negative value maps onto itself, read as unsigned 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             s);
        return (s && v[WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

    // Two's-complement negation when requested; wraps on the most negative value.
    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                    input logic             neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    assign shifted = {prem, shreg[WIDTH-1]};
    assign diff    = shifted - {1'b0, b_mag};
    assign busy    = (state == RUN) || (state == FIX);

    // Control: FSM, step counter and the registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            done  <= 1'b0;
            Q     <= '0;
            R     <= '0;
            E     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (B == '0) begin
                            state <= FIX;
                        end else begin
                            state <= RUN;
                            count <= CW'(WIDTH);
                        end
                    end
                end
                RUN: begin
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    done  <= 1'b1;
                    state <= IDLE;
                    if (zero) begin
                        Q <= '1;
                        R <= a_raw;
                        E <= 1'b1;
                    end else begin
                        Q <= apply_sign(shreg, neg_q);
                        R <= apply_sign(prem, neg_r);
                        E <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Datapath: operand capture on an accepted start, then one shift/subtract
    // per RUN cycle. Quotient bits enter shreg from the LSB as dividend bits leave the MSB.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (start) begin
                    a_raw <= A;
                    shreg <= magnitude(A, sinal);
                    b_mag <= magnitude(B, sinal);
                    prem  <= '0;
                    neg_q <= sinal && (A[WIDTH-1] ^ B[WIDTH-1]);
                    neg_r <= sinal && A[WIDTH-1];
                    zero  <= (B == '0);
                end
            end
            RUN: begin
                if (!diff[WIDTH]) begin
                    prem  <= diff[WIDTH-1:0];
                    shreg <= {shreg[WIDTH-2:0], 1'b1};
                end else begin
                    prem  <= shifted[WIDTH-1:0];
                    shreg <= {shreg[WIDTH-2:0], 1'b0};
                end
            end
            default: begin
            end
        endcase
    end

endmodule
